// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
//
// Bundles the instruction-in / immediate-out handshake of imm_gen_pipe.
//
//   flush      producer -> block   discard every buffered entry
//   in_valid   producer -> block   inst is valid this cycle
//   in_ready   block -> producer   block can accept inst
//   inst       producer -> block   32-bit instruction word
//   out_valid  block -> consumer   head entry valid
//   out_ready  consumer -> block   consumer takes the head entry
//   imm        block -> consumer   sign-extended immediate of head entry
//   fmt        block -> consumer   format tag of head entry
//   is_rvc     block -> consumer   head entry came from a 16-bit instruction
//
// master: the surrounding pipeline (drives inst, takes results)
// slave : the immediate generator itself
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            is_rvc;

    modport master (
        output flush, in_valid, inst, out_ready,
        input  in_ready, out_valid, imm, fmt, is_rvc
    );

    modport slave (
        input  flush, in_valid, inst, out_ready,
        output in_ready, out_valid, imm, fmt, is_rvc
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Decode-stage RISC-V immediate generator. Each accepted instruction word is
// decoded to a format tag and an XLEN-wide sign-extended immediate, and the
// result is parked in a 2-entry FIFO so fetch keeps flowing while execute
// back-pressures.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      imm_gen_pipe_if.slave (flush, in/out valid-ready, inst, imm,
//            fmt, is_rvc)
//
// fmt encoding: 0=I 1=S 2=B 3=U 4=J 5=CI 6=CB/CJ 7=NONE
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int ENABLE_C = 0,
    parameter int DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_CI   = 3'd5;
    localparam logic [2:0] FMT_CBJ  = 3'd6;
    localparam logic [2:0] FMT_NONE = 3'd7;

    if (!(XLEN == 32 || XLEN == 64) || DEPTH != 2) begin : g_param_check
        $error("imm_gen_pipe: XLEN must be 32 or 64 and DEPTH must be 2");
    end

    typedef struct packed {
        logic            is_rvc;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
    } entry_t;

    // Every raw immediate is already sign-extended to 32 bits, so widening
    // to XLEN is a plain signed cast.
    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // ---------------- decode (combinational on the incoming word) ----------
    logic [4:0]         opcode;
    logic [2:0]         funct3;
    logic signed [31:0] raw_i;
    logic signed [31:0] raw_s;
    logic signed [31:0] raw_b;
    logic signed [31:0] raw_u;
    logic signed [31:0] raw_j;
    logic signed [31:0] raw_ci;
    logic signed [31:0] raw_cj;
    logic signed [31:0] raw_cb;

    assign opcode = bus.inst[6:2];
    assign funct3 = bus.inst[15:13];

    assign raw_i  = {{20{bus.inst[31]}}, bus.inst[31:20]};
    assign raw_s  = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
    assign raw_b  = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                     bus.inst[30:25], bus.inst[11:8], 1'b0};
    assign raw_u  = {bus.inst[31:12], 12'b0};
    assign raw_j  = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                     bus.inst[20], bus.inst[30:21], 1'b0};
    assign raw_ci = {{26{bus.inst[12]}}, bus.inst[12], bus.inst[6:2]};
    // c.j / c.jal: inst[12:2] holds offset[11|4|9:8|10|6|7|3:1|5]
    assign raw_cj = {{20{bus.inst[12]}}, bus.inst[12], bus.inst[8],
                     bus.inst[10:9], bus.inst[6], bus.inst[7], bus.inst[2],
                     bus.inst[11], bus.inst[5:3], 1'b0};
    // c.beqz / c.bnez: offset[8|4:3] in inst[12:10], offset[7:6|2:1|5] in inst[6:2]
    assign raw_cb = {{23{bus.inst[12]}}, bus.inst[12], bus.inst[6:5],
                     bus.inst[2], bus.inst[11:10], bus.inst[4:3], 1'b0};

    logic signed [31:0] dec_raw;
    logic [2:0]         dec_fmt;
    logic               dec_rvc;
    entry_t             dec_entry;

    always_comb begin
        dec_raw = '0;
        dec_fmt = FMT_NONE;
        dec_rvc = 1'b0;
        if (bus.inst[1:0] == 2'b11) begin
            case (opcode)
                5'b00000, 5'b00100, 5'b11001, 5'b00011, 5'b11100: begin
                    dec_fmt = FMT_I;
                    dec_raw = raw_i;
                end
                5'b01000: begin
                    dec_fmt = FMT_S;
                    dec_raw = raw_s;
                end
                5'b11000: begin
                    dec_fmt = FMT_B;
                    dec_raw = raw_b;
                end
                5'b01101, 5'b00101: begin
                    dec_fmt = FMT_U;
                    dec_raw = raw_u;
                end
                5'b11011: begin
                    dec_fmt = FMT_J;
                    dec_raw = raw_j;
                end
                default: begin
                    dec_fmt = FMT_NONE;
                    dec_raw = '0;
                end
            endcase
        end else if (ENABLE_C != 0) begin
            // Any 16-bit encoding is tagged RVC even when it has no immediate.
            dec_rvc = 1'b1;
            if (bus.inst[1:0] == 2'b01) begin
                case (funct3)
                    3'b000, 3'b010: begin
                        dec_fmt = FMT_CI;
                        dec_raw = raw_ci;
                    end
                    3'b001: begin
                        // c.jal exists only on RV32; on RV64 this slot is c.addiw.
                        if (XLEN == 32) begin
                            dec_fmt = FMT_CBJ;
                            dec_raw = raw_cj;
                        end
                    end
                    3'b101: begin
                        dec_fmt = FMT_CBJ;
                        dec_raw = raw_cj;
                    end
                    3'b110, 3'b111: begin
                        dec_fmt = FMT_CBJ;
                        dec_raw = raw_cb;
                    end
                    default: begin
                        dec_fmt = FMT_NONE;
                        dec_raw = '0;
                    end
                endcase
            end
        end
    end

    assign dec_entry = {dec_rvc, dec_fmt, sext32(dec_raw)};

    // ---------------- 2-entry output FIFO ----------------------------------
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    entry_t     mem_q [0:1];
    entry_t     mem_d [0:1];
    logic       push;
    logic       pop;
    logic       out_valid;
    entry_t     head;

    assign out_valid    = (count_q != 2'd0);
    assign bus.in_ready = (count_q < 2'd2);
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = out_valid & bus.out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (bus.flush) begin
            // Flush wins over any same-cycle push or pop.
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; the empty-FIFO gating below keeps
    // stale or unknown contents off the outputs.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ---------------- head outputs -----------------------------------------
    assign head          = mem_q[rd_ptr_q];
    assign bus.out_valid = out_valid;
    assign bus.imm       = out_valid ? head.imm    : '0;
    assign bus.fmt       = out_valid ? head.fmt    : FMT_NONE;
    assign bus.is_rvc    = out_valid ? head.is_rvc : 1'b0;

endmodule
